bus_ram: RTL
============

BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 128, giving the number of populated bytes at addresses 0..DEPTH-1 (legal range 1..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted before each response (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port addr_bus, input, 8 bits: byte address driven by the CPU.
REQ-006 SHALL have port data_bus, inout tri, 8 bits: shared bidirectional data bus, high-Z whenever the block is not driving.
REQ-007 SHALL have port mem_rd, input, 1 bit: read request, held by the CPU until mem_ready is seen.
REQ-008 SHALL have port mem_wr, input, 1 bit: write request, held by the CPU until mem_ready is seen.
REQ-009 SHALL have port mem_ready, output, 1 bit: registered single-cycle response strobe.
REQ-010 SHALL have port nomem_flag, output, 1 bit: registered flag marking an access to an unpopulated address, valid only while mem_ready=1.

Function
REQ-011 SHALL use four states: IDLE, WAIT, RESP and DONE.
REQ-012 In IDLE, a rising edge with exactly one of mem_rd or mem_wr high SHALL accept the request.
  - On acceptance, latch addr_bus, the request type and, for writes, data_bus.
  - Go to WAIT if WAIT_CYCLES>0, otherwise directly to RESP.
REQ-013 If mem_rd and mem_wr are both high in IDLE, the block SHALL ignore the request, stay in IDLE, and neither respond nor drive the bus.
REQ-014 WAIT SHALL last exactly WAIT_CYCLES clock periods, counted by a 4-bit down-counter, and then go to RESP.
  - addr_bus and data_bus changes during WAIT SHALL be ignored.
REQ-015 mem_ready SHALL be high only during RESP, which lasts exactly one period.
  - For a request sampled at edge k, RESP is the period following edge k+WAIT_CYCLES.
REQ-016 A write to a latched address below DEPTH SHALL commit the latched data to the array on the edge that enters RESP.
REQ-017 A read to a latched address below DEPTH SHALL drive data_bus with mem[addr] from the start of RESP.
  - Drive continues through DONE for as long as mem_rd stays high.
  - data_bus releases to high-Z combinationally when mem_rd falls.
REQ-018 For a latched address at or above DEPTH:
  - nomem_flag SHALL be high in the RESP cycle.
  - A read SHALL drive 8'hFF under the same rules as REQ-017.
  - A write SHALL be discarded.
REQ-019 RESP SHALL go to DONE unconditionally.
  - DONE SHALL return to IDLE on the first edge at which both mem_rd and mem_wr are low.
  - A request held high therefore produces exactly one mem_ready pulse.
REQ-020 data_bus SHALL be high-Z in IDLE and WAIT, for every write, and for any cycle in which mem_rd is low.
REQ-021 nomem_flag SHALL be 0 whenever mem_ready is 0.

Reset
REQ-022 While rst=1, the block SHALL force state to IDLE, the counter to 0, mem_ready=0, nomem_flag=0 and data_bus to high-Z, all immediately and without waiting for clk.
REQ-023 Reset SHALL NOT clear the memory array; its contents are undefined only at power-up.
REQ-024 Reset asserted during WAIT SHALL abort the pending access; a pending write is not committed.

Verification
REQ-025 Pulse rst -> mem_ready=0, nomem_flag=0, data_bus=Z, with no clock edge needed.
REQ-026 Write 0x5A to 0x10 with WAIT_CYCLES=2 -> mem_ready high in the third period after the request edge, nomem_flag=0.
  - A following read of 0x10 -> data_bus=0x5A with mem_ready; Z after mem_rd falls.
REQ-027 Read 0x90 with DEPTH=128 -> mem_ready=1, nomem_flag=1, data_bus=0xFF.
  - Write 0x77 to 0x90, then read 0x00 -> 0x00 unchanged from its prior write.
REQ-028 mem_rd=mem_wr=1 held 20 cycles -> mem_ready stays 0 and data_bus stays Z.
REQ-029 Write 0x11 to 0x20, then start a write of 0x33 to 0x20 and assert rst during WAIT -> a later read of 0x20 returns 0x11.
REQ-030 Hold mem_rd high for 10 cycles after mem_ready with WAIT_CYCLES=0 -> exactly one mem_ready pulse.
  - Changing addr_bus after the request edge -> data from the originally latched address.

Source files
------------

// File: rtl/bus_ram.sv
// bus_ram: byte-wide RAM slave on a shared bidirectional CPU bus.
// A request is accepted in IDLE, optionally delayed by WAIT_CYCLES wait states,
// then answered with a single-cycle mem_ready strobe. Reads keep driving the bus
// until the CPU drops mem_rd. Addresses at or above DEPTH are unpopulated: they
// raise nomem_flag, read as 8'hFF and discard writes.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (memory contents are kept)
//   addr_bus   - byte address from the CPU
//   data_bus   - shared data bus, high-Z unless returning read data
//   mem_rd     - read request, held until mem_ready
//   mem_wr     - write request, held until mem_ready
//   mem_ready  - registered one-cycle response strobe
//   nomem_flag - registered unpopulated-address flag, qualified by mem_ready
module bus_ram #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_bus,
  inout  tri   [7:0] data_bus,
  input  logic       mem_rd,
  input  logic       mem_wr,
  output logic       mem_ready,
  output logic       nomem_flag
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            is_wr_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            req_ok_c;
  logic            enter_resp_c;
  logic [AW-1:0]   resp_addr_c;
  logic [DW-1:0]   resp_data_c;
  logic            resp_wr_c;
  logic            hit_c;
  logic            commit_c;
  logic            drive_c;

  // With no wait states the response is set up from the live bus in the
  // accepting edge; otherwise from the values latched at acceptance.
  always_comb begin
    req_ok_c     = mem_rd ^ mem_wr;
    enter_resp_c = 1'b0;
    if (state_q == IDLE && req_ok_c && WAIT_CYCLES == 0)
      enter_resp_c = 1'b1;
    if (state_q == WAIT && cnt_q == CW'(1))
      enter_resp_c = 1'b1;
    resp_addr_c  = (state_q == IDLE) ? addr_bus : addr_q;
    resp_data_c  = (state_q == IDLE) ? data_bus : wdata_q;
    resp_wr_c    = (state_q == IDLE) ? mem_wr   : is_wr_q;
    hit_c        = 32'(resp_addr_c) < DEPTH;
    commit_c     = enter_resp_c && resp_wr_c && hit_c && !rst;
    drive_c      = (state_q == RESP || state_q == DONE) && !is_wr_q && mem_rd;
  end

  // Read data is released combinationally as soon as mem_rd falls.
  assign data_bus = drive_c ? rdata_q : {DW{1'bz}};

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit_c)
      mem[resp_addr_c[IW-1:0]] <= resp_data_c;
  end

  // Access sequencer with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
      mem_ready  <= 1'b0;
      nomem_flag <= 1'b0;
    end else begin
      mem_ready  <= 1'b0;
      nomem_flag <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_ok_c) begin
            addr_q  <= addr_bus;
            wdata_q <= data_bus;
            is_wr_q <= mem_wr;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= CW'(WAIT_CYCLES);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_q <= RESP;
        end
        RESP: state_q <= DONE;
        DONE: begin
          if (!mem_rd && !mem_wr)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (enter_resp_c) begin
        mem_ready  <= 1'b1;
        nomem_flag <= !hit_c;
        rdata_q    <= hit_c ? mem[resp_addr_c[IW-1:0]] : 8'hFF;
      end
    end
  end

endmodule
